syn_fetch_queue: RTL and testbench



---
 rtl/syn_fetch_queue_pkg.sv | 21 ++
 rtl/syn_fq_mem.sv | 25 ++
 rtl/syn_fetch_queue.sv | 74 +++++++
 tb/tb_syn_fetch_queue.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/syn_fetch_queue_pkg.sv
// Shared sizing for the fetch queue. Decode and PC stages import this so
// their stall logic agrees with the queue depth.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 10
`endif
`ifndef FQ_DEPTH
`define FQ_DEPTH 4
`endif

package syn_fetch_queue_pkg;

    localparam int FQ_DEPTH  = `FQ_DEPTH;
    localparam int FQ_ADDR_W = `IM_ADDR_BIT;
    localparam int FQ_DATA_W = 32;

    // One stored entry is {guessed, pc_4, pc, instr}.
    function automatic int fq_entry_w(input int aw, input int dw);
        return 2 * aw + dw + 1;
    endfunction

endpackage

// File: rtl/syn_fq_mem.sv
// Entry storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; occupancy is tracked by the owner.
module syn_fq_mem #(
    parameter int DEPTH = 4,
    parameter int EW    = 53,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [EW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [EW-1:0] rdata
);

    logic [DEPTH-1:0][EW-1:0] mem;

    // Write the addressed entry on an accepted push.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/syn_fetch_queue.sv
// Fetch buffer between IM/PC and decode. Upstream stalls on !in_ready;
// decode drains with valid/ready. A mispredict flush empties it in one edge.
module syn_fetch_queue
    import syn_fetch_queue_pkg::*;
#(
    parameter int DEPTH  = FQ_DEPTH,
    parameter int ADDR_W = FQ_ADDR_W,
    parameter int DATA_W = FQ_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_pc,
    input  logic [ADDR_W-1:0]          in_pc_4,
    input  logic [DATA_W-1:0]          in_instr,
    input  logic                       in_guessed,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [ADDR_W-1:0]          out_pc_4,
    output logic [DATA_W-1:0]          out_instr,
    output logic                       out_guessed,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = fq_entry_w(ADDR_W, DATA_W);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] wdata, rdata;
    logic          push, pop, we;

    // Ready/valid depend on occupancy only, so a full queue refuses a push
    // even when decode pops in the same cycle (no out_ready -> in_ready path).
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign we        = push && !flush && !rst;
    assign wdata     = {in_guessed, in_pc_4, in_pc, in_instr};

    syn_fq_mem #(.DEPTH(DEPTH), .EW(EW)) u_mem (
        .clk  (clk),
        .we   (we),
        .waddr(wr_ptr),
        .wdata(wdata),
        .raddr(rd_ptr),
        .rdata(rdata)
    );

    // Head is a combinational read, zeroed while empty so decode sees no stale data.
    assign {out_guessed, out_pc_4, out_pc, out_instr} = out_valid ? rdata : '0;

    // Pointer/occupancy update: reset beats flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_syn_fetch_queue.sv
module tb_syn_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [AW-1:0] pc;
        logic [AW-1:0] pc4;
        logic [DW-1:0] instr;
        logic          g;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_pc = '0;
    logic [AW-1:0] in_pc_4 = '0;
    logic [DW-1:0] in_instr = '0;
    logic          in_guessed = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_pc;
    logic [AW-1:0] out_pc_4;
    logic [DW-1:0] out_instr;
    logic          out_guessed;
    logic [CW-1:0] count;

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t sb[$];

    always #5 clk = ~clk;

    syn_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_pc_4(in_pc_4), .in_instr(in_instr), .in_guessed(in_guessed),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc_4(out_pc_4), .out_instr(out_instr), .out_guessed(out_guessed),
        .count(count)
    );

    // Present an entry derived from pc (inputs change at negedge only).
    task automatic drive(input logic v, input logic [AW-1:0] pc);
        in_valid   = v;
        in_pc      = pc;
        in_pc_4    = pc + AW'(1);
        in_instr   = {22'h2a5a5, pc} ^ 32'h1357_0000;
        in_guessed = pc[0];
    endtask

    // Advance one edge and update the reference model with what the edge should do.
    task automatic tick();
        bit   pu, po;
        ent_t e, d;
        pu = in_valid && (sb.size() != DEPTH);
        po = out_ready && (sb.size() != 0);
        e.pc = in_pc; e.pc4 = in_pc_4; e.instr = in_instr; e.g = in_guessed;
        @(posedge clk);
        if (rst || flush) sb.delete();
        else begin
            if (po) d = sb.pop_front();
            if (pu) sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
        n_cmp++; if (count !== '0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
        n_cmp++; if (out_pc !== '0 || out_instr !== '0) begin n_err++; $display("FAIL rst_out_zero got pc=%h instr=%h want 0", out_pc, out_instr); end
        in_valid = 1'b1; in_pc = 10'h10; in_pc_4 = 10'h11; in_instr = 32'hDEADBEEF; in_guessed = 1'b1;
        tick(); in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || count !== CW'(1)) begin n_err++; $display("FAIL first_push got valid=%0b count=%0d want 1/1", out_valid, count); end
        n_cmp++; if (out_pc !== 10'h10 || out_pc_4 !== 10'h11 || out_instr !== 32'hDEADBEEF || out_guessed !== 1'b1)
            begin n_err++; $display("FAIL first_data got %h %h %h %b want 010 011 deadbeef 1", out_pc, out_pc_4, out_instr, out_guessed); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || count !== CW'(sb.size())) begin n_err++; $display("FAIL first_drain got valid=%0b count=%0d want 0/0", out_valid, count); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin drive(1'b1, AW'(i)); tick(); end
        n_cmp++; if (count !== CW'(DEPTH) || in_ready !== 1'b0) begin n_err++; $display("FAIL full got count=%0d in_ready=%0b want 4/0", count, in_ready); end
        drive(1'b1, AW'(4)); tick(); drive(1'b0, '0);
        n_cmp++; if (count !== CW'(DEPTH) || sb.size() != DEPTH) begin n_err++; $display("FAIL full_refuse got count=%0d want 4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (sb.size() == 0 || out_valid !== 1'b1 || out_pc !== AW'(i) || out_pc !== sb[0].pc || out_instr !== sb[0].instr || out_guessed !== sb[0].g)
                begin n_err++; $display("FAIL drain_order got valid=%0b pc=%h want pc=%h", out_valid, out_pc, AW'(i)); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || count !== '0) begin n_err++; $display("FAIL drain_empty got valid=%0b count=%0d want 0/0", out_valid, count); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 2; i++) begin drive(1'b1, AW'(i)); tick(); end
        out_ready = 1'b1;
        for (int i = 2; i < 10; i++) begin
            drive(1'b1, AW'(i));
            n_cmp++;
            if (sb.size() == 0 || count !== CW'(2) || out_pc !== AW'(i - 2) || out_pc_4 !== sb[0].pc4 || out_instr !== sb[0].instr)
                begin n_err++; $display("FAIL wrap got count=%0d pc=%h want 2 pc=%h", count, out_pc, AW'(i - 2)); end
            tick();
        end
        drive(1'b0, '0);
        for (int i = 8; i < 10; i++) begin
            n_cmp++; if (out_pc !== AW'(i)) begin n_err++; $display("FAIL wrap_tail got pc=%h want %h", out_pc, AW'(i)); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_empty got valid=%0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) begin drive(1'b1, AW'(10'h20 + i)); tick(); end
        drive(1'b1, 10'h24); out_ready = 1'b1;
        n_cmp++; if (in_ready !== 1'b0 || out_pc !== 10'h20) begin n_err++; $display("FAIL full_pop_cycle got in_ready=%0b pc=%h want 0/020", in_ready, out_pc); end
        tick(); out_ready = 1'b0;
        n_cmp++; if (count !== CW'(3) || in_ready !== 1'b1) begin n_err++; $display("FAIL full_pop_count got %0d/%0b want 3/1", count, in_ready); end
        tick(); drive(1'b0, '0);
        n_cmp++; if (count !== CW'(4)) begin n_err++; $display("FAIL retry_push got count=%0d want 4", count); end
        out_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            n_cmp++;
            if (sb.size() == 0 || out_pc !== AW'(10'h20 + i) || out_instr !== sb[0].instr)
                begin n_err++; $display("FAIL b2b_order got pc=%h want %h", out_pc, AW'(10'h20 + i)); end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin drive(1'b1, AW'(10'h30 + i)); tick(); end
        n_cmp++; if (count !== CW'(3)) begin n_err++; $display("FAIL pre_flush got count=%0d want 3", count); end
        flush = 1'b1; drive(1'b1, 10'h33); out_ready = 1'b1;
        tick();
        flush = 1'b0; drive(1'b0, '0); out_ready = 1'b0;
        n_cmp++; if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== '0)
            begin n_err++; $display("FAIL flush got count=%0d valid=%0b ready=%0b pc=%h want 0/0/1/0", count, out_valid, in_ready, out_pc); end
        drive(1'b1, 10'h40); tick(); drive(1'b0, '0);
        n_cmp++; if (count !== CW'(1) || out_pc !== 10'h40 || out_pc !== sb[0].pc) begin n_err++; $display("FAIL post_flush got count=%0d pc=%h want 1/040", count, out_pc); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_flush_stale got valid=%0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin drive(1'b1, AW'(10'h50 + i)); tick(); end
        rst = 1'b1; flush = 1'b1; drive(1'b1, 10'h52);
        tick();
        rst = 1'b0; flush = 1'b0; drive(1'b0, '0);
        n_cmp++; if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid got count=%0d valid=%0b want 0/0", count, out_valid); end
        for (int i = 0; i < 2; i++) begin drive(1'b1, AW'(10'h60 + i)); tick(); end
        drive(1'b0, '0);
        rst = 1'b1; #2; rst = 1'b0;
        tick();
        n_cmp++; if (count !== CW'(2) || out_pc !== 10'h60) begin n_err++; $display("FAIL rst_glitch got count=%0d pc=%h want 2/060", count, out_pc); end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (sb.size() == 0 || out_pc !== sb[0].pc || out_pc_4 !== sb[0].pc4 || out_guessed !== sb[0].g)
                begin n_err++; $display("FAIL glitch_drain got pc=%h want %h", out_pc, AW'(10'h60 + i)); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (count !== CW'(sb.size()) || out_valid !== 1'b0) begin n_err++; $display("FAIL final_empty got count=%0d want 0", count); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
